// File: rtl/jtframe_lfbuf_ddr_pkg.sv
// Shared definitions for the line frame buffer DDR arbiter: FSM state encoding,
// DDR port widths and the burst length normalisation helper.
package jtframe_lfbuf_ddr_pkg;

  localparam int DW  = 64;
  localparam int BEW = 8;
  localparam int BCW = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR     = 2'd1,
    ST_RDCMD  = 2'd2,
    ST_RDDATA = 2'd3
  } arb_state_t;

  // A zero burst count means a single beat
  function automatic logic [BCW-1:0] burst_len(input logic [BCW-1:0] bc);
    logic [BCW-1:0] len;
    if (bc == {BCW{1'b0}}) begin
      len = {{(BCW-1){1'b0}}, 1'b1};
    end else begin
      len = bc;
    end
    return len;
  endfunction

endpackage

// File: rtl/jtframe_lfbuf_ddr_arb_cnt.sv
// Burst beat counter shared by the write and read-data phases. Holds the number
// of beats still owed; zero means no burst is in progress.
module jtframe_lfbuf_ddr_arb_cnt
  import jtframe_lfbuf_ddr_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           dec,
  input  logic [BCW-1:0] len,
  output logic           empty,
  output logic           last
);

  logic [BCW-1:0] cnt_q, cnt_d;
  logic [BCW-1:0] len_n;

  // Load may coincide with the first beat of a write burst
  always_comb begin
    len_n = burst_len(len);
    if (load && dec) begin
      cnt_d = len_n - {{(BCW-1){1'b0}}, 1'b1};
    end else if (load) begin
      cnt_d = len_n;
    end else if (dec && (cnt_q != {BCW{1'b0}})) begin
      cnt_d = cnt_q - {{(BCW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {BCW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    empty = (cnt_q == {BCW{1'b0}});
    if (load) begin
      last = dec & (len_n == {{(BCW-1){1'b0}}, 1'b1});
    end else begin
      last = dec & (cnt_q == {{(BCW-1){1'b0}}, 1'b1});
    end
  end

endmodule

// File: rtl/jtframe_lfbuf_ddr_arb.sv
// Burst-level arbiter sharing one DDR port between the line frame buffer (c0)
// and a general requester (c1). Define JTFRAME_LFBUF_ARB_STATS_EN for grant statistics.
module jtframe_lfbuf_ddr_arb
  import jtframe_lfbuf_ddr_pkg::*;
#(
  parameter int AW      = 29,
  parameter int WAITW   = 6,
  parameter int MAXWAIT = 48
) (
  input  logic           clk,
  input  logic           rst,

  input  logic [AW-1:0]  c0_addr,
  input  logic [BCW-1:0] c0_burstcnt,
  input  logic           c0_rd,
  input  logic           c0_we,
  input  logic [DW-1:0]  c0_din,
  input  logic [BEW-1:0] c0_be,
  output logic           c0_busy,
  output logic           c0_dout_ready,

  input  logic [AW-1:0]  c1_addr,
  input  logic [BCW-1:0] c1_burstcnt,
  input  logic           c1_rd,
  input  logic           c1_we,
  input  logic [DW-1:0]  c1_din,
  input  logic [BEW-1:0] c1_be,
  output logic           c1_busy,
  output logic           c1_dout_ready,

  output logic [DW-1:0]  dout,

  output logic           ddram_clk,
  input  logic           ddram_busy,
  output logic [AW-1:0]  ddram_addr,
  output logic [BCW-1:0] ddram_burstcnt,
  output logic           ddram_rd,
  output logic           ddram_we,
  output logic [DW-1:0]  ddram_din,
  output logic [BEW-1:0] ddram_be,
  input  logic [DW-1:0]  ddram_dout,
  input  logic           ddram_dout_ready,

  output logic           grant
`ifdef JTFRAME_LFBUF_ARB_STATS_EN
  ,
  output logic [15:0]    c0_bursts,
  output logic [15:0]    c1_bursts,
  output logic [15:0]    c1_forced
`endif
);

  localparam logic [WAITW-1:0] MAXW = WAITW'(MAXWAIT);

  arb_state_t       state_q, state_d;
  logic             grant_q, grant_d;
  logic             bubble_q, bubble_d;
  logic [WAITW-1:0] waitcnt_q, waitcnt_d;

  logic             req0_s, req1_s, forced_s, win_s, win_we_s;
  logic [AW-1:0]    sel_addr_s;
  logic [BCW-1:0]   sel_bc_s;
  logic [DW-1:0]    sel_din_s;
  logic [BEW-1:0]   sel_be_s;
  logic             sel_rd_s, sel_we_s;
  logic             wr_beat_s, rd_acc_s, rd_beat_s;
  logic             cnt_load_s, cnt_dec_s, cnt_empty_s, cnt_last_s;

  assign ddram_clk = clk;
  assign dout      = ddram_dout;
  assign grant     = grant_q;

  // Right after a write the previous owner yields to a waiting peer for one arbitration
  always_comb begin
    req0_s   = c0_rd | c0_we;
    req1_s   = c1_rd | c1_we;
    forced_s = req1_s & (waitcnt_q == MAXW);
    win_s    = req1_s & (~req0_s | forced_s | (bubble_q & ~grant_q));
    win_we_s = win_s ? c1_we : c0_we;
  end

  always_comb begin
    if (grant_q) begin
      sel_addr_s = c1_addr;
      sel_bc_s   = c1_burstcnt;
      sel_din_s  = c1_din;
      sel_be_s   = c1_be;
      sel_rd_s   = c1_rd;
      sel_we_s   = c1_we;
    end else begin
      sel_addr_s = c0_addr;
      sel_bc_s   = c0_burstcnt;
      sel_din_s  = c0_din;
      sel_be_s   = c0_be;
      sel_rd_s   = c0_rd;
      sel_we_s   = c0_we;
    end
  end

  always_comb begin
    wr_beat_s  = (state_q == ST_WR) & sel_we_s & ~ddram_busy;
    rd_acc_s   = (state_q == ST_RDCMD) & sel_rd_s & ~ddram_busy;
    rd_beat_s  = (state_q == ST_RDDATA) & ddram_dout_ready;
    cnt_load_s = (wr_beat_s & cnt_empty_s) | rd_acc_s;
    cnt_dec_s  = wr_beat_s | rd_beat_s;
  end

  jtframe_lfbuf_ddr_arb_cnt u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load_s),
    .dec   (cnt_dec_s),
    .len   (sel_bc_s),
    .empty (cnt_empty_s),
    .last  (cnt_last_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      bubble_q  <= 1'b0;
      waitcnt_q <= {WAITW{1'b0}};
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      bubble_q  <= bubble_d;
      waitcnt_q <= waitcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    bubble_d  = 1'b0;
    waitcnt_d = waitcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_s || req1_s) begin
          grant_d = win_s;
          state_d = win_we_s ? ST_WR : ST_RDCMD;
          if (win_s) begin
            waitcnt_d = {WAITW{1'b0}};
          end else if (req1_s && (waitcnt_q != MAXW)) begin
            waitcnt_d = waitcnt_q + {{(WAITW-1){1'b0}}, 1'b1};
          end else begin
            waitcnt_d = waitcnt_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (cnt_last_s) begin
          state_d  = ST_IDLE;
          bubble_d = 1'b1;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RDCMD: begin
        if (rd_acc_s) begin
          state_d = ST_RDDATA;
        end else begin
          state_d = ST_RDCMD;
        end
      end
      ST_RDDATA: begin
        if (cnt_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RDDATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes reach the DDR only in the phase that owns them; stray read beats go nowhere
  always_comb begin
    ddram_addr     = sel_addr_s;
    ddram_burstcnt = burst_len(sel_bc_s);
    ddram_din      = sel_din_s;
    ddram_be       = sel_be_s;
    ddram_rd       = 1'b0;
    ddram_we       = 1'b0;
    c0_busy        = 1'b1;
    c1_busy        = 1'b1;
    c0_dout_ready  = 1'b0;
    c1_dout_ready  = 1'b0;
    case (state_q)
      ST_WR, ST_RDCMD: begin
        ddram_we = (state_q == ST_WR) & sel_we_s;
        ddram_rd = (state_q == ST_RDCMD) & sel_rd_s;
        if (grant_q) begin
          c1_busy = ddram_busy;
        end else begin
          c0_busy = ddram_busy;
        end
      end
      ST_RDDATA: begin
        if (grant_q) begin
          c1_dout_ready = ddram_dout_ready;
        end else begin
          c0_dout_ready = ddram_dout_ready;
        end
      end
      default: begin
        ddram_rd = 1'b0;
      end
    endcase
  end

`ifdef JTFRAME_LFBUF_ARB_STATS_EN
  logic        grant_ev_s;
  logic [15:0] c0_bursts_q, c0_bursts_d;
  logic [15:0] c1_bursts_q, c1_bursts_d;
  logic [15:0] c1_forced_q, c1_forced_d;

  // Saturating grant statistics; a forced grant is one taken from a requesting c0
  always_comb begin
    grant_ev_s  = (state_q == ST_IDLE) & (req0_s | req1_s);
    c0_bursts_d = c0_bursts_q;
    c1_bursts_d = c1_bursts_q;
    c1_forced_d = c1_forced_q;
    if (grant_ev_s && !win_s && (c0_bursts_q != 16'hFFFF)) begin
      c0_bursts_d = c0_bursts_q + 16'd1;
    end else begin
      c0_bursts_d = c0_bursts_q;
    end
    if (grant_ev_s && win_s && (c1_bursts_q != 16'hFFFF)) begin
      c1_bursts_d = c1_bursts_q + 16'd1;
    end else begin
      c1_bursts_d = c1_bursts_q;
    end
    if (grant_ev_s && win_s && forced_s && req0_s && (c1_forced_q != 16'hFFFF)) begin
      c1_forced_d = c1_forced_q + 16'd1;
    end else begin
      c1_forced_d = c1_forced_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0_bursts_q <= 16'd0;
      c1_bursts_q <= 16'd0;
      c1_forced_q <= 16'd0;
    end else begin
      c0_bursts_q <= c0_bursts_d;
      c1_bursts_q <= c1_bursts_d;
      c1_forced_q <= c1_forced_d;
    end
  end

  assign c0_bursts = c0_bursts_q;
  assign c1_bursts = c1_bursts_q;
  assign c1_forced = c1_forced_q;
`endif

endmodule

// File: tb/tb_jtframe_lfbuf_ddr_arb.sv
// Directed self-checking bench for jtframe_lfbuf_ddr_arb (default build).
module tb_jtframe_lfbuf_ddr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [28:0] c0_addr, c1_addr;
  logic [7:0]  c0_burstcnt, c1_burstcnt;
  logic        c0_rd, c0_we, c1_rd, c1_we;
  logic [63:0] c0_din, c1_din;
  logic [7:0]  c0_be, c1_be;
  logic        c0_busy, c1_busy, c0_dout_ready, c1_dout_ready;
  logic [63:0] dout;
  logic        ddram_clk, ddram_busy, ddram_rd, ddram_we, ddram_dout_ready;
  logic [28:0] ddram_addr;
  logic [7:0]  ddram_burstcnt, ddram_be;
  logic [63:0] ddram_din, ddram_dout;
  logic        grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtframe_lfbuf_ddr_arb dut (
    .clk(clk), .rst(rst),
    .c0_addr(c0_addr), .c0_burstcnt(c0_burstcnt), .c0_rd(c0_rd), .c0_we(c0_we),
    .c0_din(c0_din), .c0_be(c0_be), .c0_busy(c0_busy), .c0_dout_ready(c0_dout_ready),
    .c1_addr(c1_addr), .c1_burstcnt(c1_burstcnt), .c1_rd(c1_rd), .c1_we(c1_we),
    .c1_din(c1_din), .c1_be(c1_be), .c1_busy(c1_busy), .c1_dout_ready(c1_dout_ready),
    .dout(dout), .ddram_clk(ddram_clk), .ddram_busy(ddram_busy), .ddram_addr(ddram_addr),
    .ddram_burstcnt(ddram_burstcnt), .ddram_rd(ddram_rd), .ddram_we(ddram_we),
    .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_dout(ddram_dout),
    .ddram_dout_ready(ddram_dout_ready), .grant(grant)
  );

  // Tasks start and end in the drive phase (1 ns after a rising edge)
  task automatic run_write(input logic cl, input logic [28:0] addr, input logic [7:0] bc,
                           input int busy_cyc, input int exp_beats, input string nm);
    int   beats, wcyc, busy_left;
    logic side_ok, own_b, oth_b;
    beats = 0; wcyc = 0; busy_left = busy_cyc; side_ok = 1'b1;
    if (cl) begin
      c1_addr = addr; c1_burstcnt = bc; c1_din = 64'hD1D1_0000_0000_0001; c1_be = 8'hF0; c1_we = 1'b1;
    end else begin
      c0_addr = addr; c0_burstcnt = bc; c0_din = 64'hD0D0_0000_0000_0001; c0_be = 8'h0F; c0_we = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (ddram_we !== 1'b0) begin
      errors++; $display("FAIL %s_early_strobe ddram_we=%b expected 0", nm, ddram_we);
    end
    @(posedge clk); #1;
    for (int t = 0; t < 100 && beats < exp_beats; t++) begin
      ddram_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      @(negedge clk);
      own_b = cl ? c1_busy : c0_busy;
      oth_b = cl ? c0_busy : c1_busy;
      if (own_b !== ddram_busy || oth_b !== 1'b1) side_ok = 1'b0;
      if (ddram_we === 1'b1) wcyc++;
      if (ddram_we === 1'b1 && ddram_busy === 1'b0) begin
        if (beats == 0) begin
          checks++;
          if (grant !== cl) begin
            errors++; $display("FAIL %s_grant got=%b expected=%b", nm, grant, cl);
          end
          checks++;
          if (ddram_addr !== addr) begin
            errors++; $display("FAIL %s_addr got=%h expected=%h", nm, ddram_addr, addr);
          end
          checks++;
          if (ddram_din !== (cl ? 64'hD1D1_0000_0000_0001 : 64'hD0D0_0000_0000_0001)) begin
            errors++; $display("FAIL %s_din got=%h", nm, ddram_din);
          end
        end
        beats++;
      end
      @(posedge clk); #1;
    end
    ddram_busy = 1'b0;
    if (cl) c1_we = 1'b0; else c0_we = 1'b0;
    checks++;
    if (beats != exp_beats) begin
      errors++; $display("FAIL %s_beats got=%0d expected=%0d", nm, beats, exp_beats);
    end
    checks++;
    if (wcyc != exp_beats + busy_cyc) begin
      errors++; $display("FAIL %s_we_cycles got=%0d expected=%0d", nm, wcyc, exp_beats + busy_cyc);
    end
    checks++;
    if (!side_ok) begin
      errors++; $display("FAIL %s_busy_routing got=bad expected=own mirrors ddram_busy, other 1", nm);
    end
    @(negedge clk);
    checks++;
    if ((cl ? c1_busy : c0_busy) !== 1'b1 || ddram_we !== 1'b0) begin
      errors++; $display("FAIL %s_idle_after busy=%b we=%b expected 1/0", nm, cl ? c1_busy : c0_busy, ddram_we);
    end
    @(posedge clk); #1;
  endtask

  // Waits for a read command to be accepted, then returns nbeats data beats
  task automatic serve_read(input int nbeats, input int gap, output logic gnt, output int waitc,
                            output int n0, output int n1, output logic [7:0] bcnt);
    logic found;
    found = 1'b0; gnt = 1'b0; waitc = 0; n0 = 0; n1 = 0; bcnt = 8'd0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      if (ddram_rd === 1'b1 && ddram_busy === 1'b0) begin
        found = 1'b1; gnt = grant; waitc = t; bcnt = ddram_burstcnt;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL read_accept got=timeout expected=ddram_rd");
    end else begin
      for (int b = 0; b < nbeats; b++) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          if (c0_dout_ready) n0++;
          if (c1_dout_ready) n1++;
          @(posedge clk); #1;
        end
        ddram_dout_ready = 1'b1;
        ddram_dout = 64'hBEEF_0000_0000_0000 + 64'(b);
        @(negedge clk);
        if (c0_dout_ready) n0++;
        if (c1_dout_ready) n1++;
        @(posedge clk); #1;
        ddram_dout_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ddram_dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 1'b0) begin errors++; $display("FAIL rst_grant got=%b expected=0", grant); end
    checks++;
    if (c0_busy !== 1'b1 || c1_busy !== 1'b1) begin
      errors++; $display("FAIL rst_busy got=%b%b expected=11", c0_busy, c1_busy);
    end
    checks++;
    if (ddram_rd !== 1'b0 || ddram_we !== 1'b0) begin
      errors++; $display("FAIL rst_strobes got=%b%b expected=00", ddram_rd, ddram_we);
    end
    checks++;
    if (c0_dout_ready !== 1'b0 || c1_dout_ready !== 1'b0) begin
      errors++; $display("FAIL rst_dout_ready got=%b%b expected=00", c0_dout_ready, c1_dout_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ddram_dout_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_c1_read;
    logic g; int w, n0, n1; logic [7:0] bc;
    c1_addr = 29'h0055_AA00; c1_burstcnt = 8'd8; c1_rd = 1'b1;
    serve_read(8, 1, g, w, n0, n1, bc);
    c1_rd = 1'b0;
    checks++;
    if (g !== 1'b1 || w != 1) begin errors++; $display("FAIL c1rd_grant got=%b/%0d expected=1/1", g, w); end
    checks++;
    if (bc !== 8'd8) begin errors++; $display("FAIL c1rd_burstcnt got=%0d expected=8", bc); end
    checks++;
    if (n1 != 8 || n0 != 0) begin errors++; $display("FAIL c1rd_beats got=%0d/%0d expected=8/0", n1, n0); end
    // A stray beat once the burst is complete must not reach either client
    ddram_dout_ready = 1'b1;
    ddram_dout = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    checks++;
    if (c0_dout_ready !== 1'b0 || c1_dout_ready !== 1'b0) begin
      errors++; $display("FAIL c1rd_stray got=%b%b expected=00", c0_dout_ready, c1_dout_ready);
    end
    checks++;
    if (dout !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL dout_pass got=%h expected=0123456789abcdef", dout);
    end
    @(posedge clk); #1;
    ddram_dout_ready = 1'b0;
  endtask

  task automatic test_starvation;
    logic g; int w, n0, n1; logic [7:0] bc; int c0wins; logic seen, leak;
    c0_burstcnt = 8'd1; c1_burstcnt = 8'd1;
    c0_rd = 1'b1; c1_rd = 1'b1;
    for (int round = 0; round < 2; round++) begin
      c0wins = 0; seen = 1'b0; leak = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        serve_read(1, 0, g, w, n0, n1, bc);
        if (round == 0 && i == 0) begin
          checks++;
          if (g !== 1'b0) begin errors++; $display("FAIL tie_c0_wins got=%b expected=0", g); end
        end
        if (g === 1'b1) seen = 1'b1;
        else begin
          c0wins++;
          if (n0 != 1 || n1 != 0) leak = 1'b1;
        end
      end
      checks++;
      if (c0wins != 48) begin
        errors++; $display("FAIL starve_round%0d got=%0d expected=48", round, c0wins);
      end
      checks++;
      if (leak) begin errors++; $display("FAIL starve_routing got=leak expected=c0 only"); end
    end
    c0_rd = 1'b0; c1_rd = 1'b0;
  endtask

  task automatic test_bubble;
    logic g; int w, n0, n1; logic [7:0] bc;
    c0_burstcnt = 8'd1; c0_we = 1'b1;
    c1_burstcnt = 8'd1; c1_rd = 1'b1;
    serve_read(1, 0, g, w, n0, n1, bc);
    c0_we = 1'b0; c1_rd = 1'b0;
    checks++;
    if (g !== 1'b1 || w != 3) begin
      errors++; $display("FAIL bubble got=grant%b at %0d expected=grant1 at 3", g, w);
    end
    checks++;
    if (n1 != 1) begin errors++; $display("FAIL bubble_beat got=%0d expected=1", n1); end
  endtask

  task automatic test_reset_mid_read;
    logic g; int w, n0, n1; logic [7:0] bc;
    c0_addr = 29'h0000_0400; c0_burstcnt = 8'd8; c0_rd = 1'b1;
    serve_read(3, 0, g, w, n0, n1, bc);
    c0_rd = 1'b0;
    checks++;
    if (g !== 1'b0 || n0 != 3) begin errors++; $display("FAIL rstmid_pre got=%b/%0d expected=0/3", g, n0); end
    ddram_dout_ready = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (ddram_rd !== 1'b0 || ddram_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_strobes got=%b%b expected=00", ddram_rd, ddram_we);
    end
    checks++;
    if (c0_busy !== 1'b1 || c1_busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy got=%b%b expected=11", c0_busy, c1_busy);
    end
    checks++;
    if (c0_dout_ready !== 1'b0 || c1_dout_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_dout_ready got=%b%b expected=00", c0_dout_ready, c1_dout_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ddram_dout_ready = 1'b0;
    run_write(1'b0, 29'h0000_0800, 8'd2, 0, 2, "post_rst");
  endtask

  initial begin
    rst = 1'b1;
    c0_addr = 29'd0; c0_burstcnt = 8'd0; c0_rd = 1'b0; c0_we = 1'b0; c0_din = 64'd0; c0_be = 8'd0;
    c1_addr = 29'd0; c1_burstcnt = 8'd0; c1_rd = 1'b0; c1_we = 1'b0; c1_din = 64'd0; c1_be = 8'd0;
    ddram_busy = 1'b0; ddram_dout = 64'd0; ddram_dout_ready = 1'b0;
    test_reset();
    run_write(1'b0, 29'h0000_1234, 8'd4, 0, 4, "c0_wr4");
    run_write(1'b0, 29'h000A_BCDE, 8'd4, 10, 4, "busy_wr");
    run_write(1'b1, 29'h0123_4560, 8'd0, 0, 1, "c1_wr0");
    test_c1_read();
    test_starvation();
    test_bubble();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtframe_lfbuf_ddr_arb.md
Name: jtframe_lfbuf_ddr_arb

Overview:
Burst-level arbiter that shares one DDR3 Avalon-style port between two masters.
- Client 0 (c0): the line frame buffer controller; video traffic, high priority.
- Client 1 (c1): a general requester, e.g. downloader or debug reader.
- Sits between both masters and the top-level ddram_* pins. Grants whole bursts and never interleaves beats from the two clients.

Parameters:
- AW, 29, DDR word address width
- WAITW, 6, width of the c1 starvation counter
- MAXWAIT, 48, number of idle-arbitration cycles c1 may lose before it is forced to win

Ports:
- clk  in  1  system clock (ddram_clk = clk)
- rst  in  1  reset, asynchronous, active-high
- cN_addr  in  AW  client N burst start address (N = 0,1; same set per client)
- cN_burstcnt  in  8  client N burst length; 0 is treated as 1
- cN_rd  in  1  client N read request
- cN_we  in  1  client N write beat strobe
- cN_din  in  64  client N write data
- cN_be  in  8  client N byte enables
- cN_busy  out  1  client N wait-request
- cN_dout_ready  out  1  client N read beat valid
- dout  out  64  read data, shared by both clients (ddram_dout passed through)
- ddram_clk  out  1  equal to clk
- ddram_busy  in  1  DDR wait-request
- ddram_addr  out  AW  DDR address
- ddram_burstcnt  out  8  DDR burst length
- ddram_rd  out  1  DDR read strobe
- ddram_we  out  1  DDR write strobe
- ddram_din  out  64  DDR write data
- ddram_be  out  8  DDR byte enables
- ddram_dout  in  64  DDR read data
- ddram_dout_ready  in  1  DDR read beat valid
- grant  out  1  granted client (0/1), for debug

Behaviour:
- States: IDLE, WR, RDCMD, RDDATA.
- Reset (async): state=IDLE, grant=0, wait counter=0, beat counter=0. All ddram strobes low; c0_busy=c1_busy=1; both dout_ready=0.
- IDLE: both cN_busy=1 and DDR strobes low.
  - Request = cN_rd | cN_we.
  - Winner is c0, unless c1 is requesting and waitcnt==MAXWAIT, then c1.
  - If only one client requests, it wins.
  - The winner is registered into grant. Next state is WR if the winner's we is set, else RDCMD; rd and we both high counts as write.
  - First DDR strobe appears 1 cycle after the request is sampled.
- Waitcnt: increments in IDLE when c1 requests and c0 wins; saturates at MAXWAIT; clears when c1 is granted.
- Routing while in WR/RDCMD:
  - ddram_addr/burstcnt/din/be/rd/we are combinationally muxed from the granted client.
  - Granted cN_busy = ddram_busy; the other client's busy stays 1.
- WR:
  - A beat counts on ddram_we & ~ddram_busy.
  - Burst length is latched on the first beat; addr is the client's, first beat only.
  - After beat burstcnt (max(burstcnt,1)), go to IDLE the next cycle. The granted client is not re-granted in that IDLE cycle if the other client is requesting (1-cycle bubble fairness).
- RDCMD: on ddram_rd & ~ddram_busy, latch burstcnt and go to RDDATA; the strobe is then dropped.
- RDDATA:
  - Strobes low and both busy=1.
  - Granted cN_dout_ready = ddram_dout_ready; the other is 0.
  - Count beats; after the last beat go to IDLE.
- Unexpected dout_ready in IDLE/WR/RDCMD is ignored and routed to no one.
- Widths: beat counter is 8 bits. Burstcnt 0 is treated as 1, so max 255 beats.
- Reset mid-burst returns to IDLE at once. Any outstanding DDR read beats must be drained by holding rst for longer than the DDR read latency; reset is held at least 150 us system-wide.

Optional Feature:
- JTFRAME_LFBUF_ARB_STATS_EN defined:
  - Adds 16-bit saturating counters c0_bursts, c1_bursts, and c1_forced (MAXWAIT-forced grants), exposed as outputs.
  - Counters clear on rst.
- Undefined: counters and ports absent; behaviour otherwise identical.

Decomposition:
- Shared package jtframe_lfbuf_ddr_pkg:
  - state encoding (IDLE=0, WR=1, RDCMD=2, RDDATA=3)
  - DDR widths (data 64, be 8, burstcnt 8)
- Sub-module jtframe_lfbuf_ddr_arb_cnt: burst beat counter, with load of max(burstcnt,1), decrement on beat, and a last-beat flag. It is instantiated once for WR and RDDATA.

Test Plan:
- c0 write, burstcnt=4, ddram_busy=0 -> 4 ddram_we beats at address c0_addr; c1_busy=1 throughout; back in IDLE 1 cycle after the 4th beat.
- c1 read, burstcnt=8, DDR returns 8 beats with gaps -> c1_dout_ready pulses 8 times, c0_dout_ready stays 0, then IDLE.
- c0 and c1 request together, c1 read pending -> c0 wins. c0 requests continuously -> c1 granted after exactly MAXWAIT=48 lost arbitrations; waitcnt returns to 0.
- ddram_busy held high 10 cycles during a c0 write -> c0_busy mirrors it; no beat counted; data completes after busy drops.
- burstcnt=0 write from c1 -> treated as 1 beat, state returns to IDLE.
- rst asserted mid-RDDATA (3 of 8 beats received) -> immediate IDLE, all strobes 0, both busy=1; after release, c0 request granted normally.
